// File: rtl/div_26b.sv
// Sequential 26-bit restoring fraction divider, 1.25 format in and out.
// One quotient bit per cycle behind a start/done handshake.
module div_26b (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic        flush,
    input  logic [25:0] frac_in1,
    input  logic [25:0] frac_in2,
    output logic        ready,
    output logic        done,
    output logic [25:0] frac_out,
    output logic        overflow,
    output logic        sticky,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [26:0] rem_q;
    logic [25:0] div_q;
    logic [25:0] quo_q;
    logic        lost_q;
    logic        ovf_q;
    logic [25:0] frac_q;
    logic        ovf_out_q;
    logic        sticky_q;
    logic        dbz_q;

    logic        accept;
    logic        acc_ovf;
    logic [25:0] a_sh;
    logic        ge;
    logic [26:0] rem_sub;
    logic [26:0] rem_d;
    logic [25:0] quo_d;

    always_comb begin
        accept  = (state_q == IDLE) && start && !flush;
        acc_ovf = {1'b0, frac_in1} >= {frac_in2, 1'b0};
        a_sh    = acc_ovf ? {1'b0, frac_in1[25:1]} : frac_in1;
        ge      = rem_q >= {1'b0, div_q};
        rem_sub = ge ? rem_q - {1'b0, div_q} : rem_q;
        // R < 2B keeps the shifted remainder inside 27 bits
        rem_d   = rem_sub << 1;
        quo_d   = {quo_q[24:0], ge};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            quo_q     <= '0;
            lost_q    <= 1'b0;
            ovf_q     <= 1'b0;
            frac_q    <= '0;
            ovf_out_q <= 1'b0;
            sticky_q  <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        frac_q    <= '0;
                        ovf_out_q <= 1'b0;
                        sticky_q  <= 1'b0;
                        dbz_q     <= 1'b0;
                        quo_q     <= '0;
                        if (frac_in2 == 26'd0) begin
                            frac_q  <= '1;
                            dbz_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rem_q   <= {1'b0, a_sh};
                            div_q   <= frac_in2;
                            ovf_q   <= acc_ovf;
                            lost_q  <= acc_ovf & frac_in1[0];
                            cnt_q   <= 5'd25;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        quo_q     <= '0;
                        frac_q    <= '0;
                        ovf_out_q <= 1'b0;
                        sticky_q  <= 1'b0;
                        dbz_q     <= 1'b0;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        if (cnt_q == 5'd0) begin
                            state_q   <= DONE;
                            frac_q    <= quo_d;
                            sticky_q  <= (rem_d != 27'd0) | lost_q;
                            ovf_out_q <= ovf_q;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    if (flush) begin
                        frac_q    <= '0;
                        ovf_out_q <= 1'b0;
                        sticky_q  <= 1'b0;
                        dbz_q     <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready       = (state_q == IDLE);
    assign done        = (state_q == DONE);
    assign frac_out    = frac_q;
    assign overflow    = ovf_out_q;
    assign sticky      = sticky_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_26b.sv
// Directed bench for div_26b: quotients, flags, latency,
// divide-by-zero, ignored start, back-to-back, reset and flush.
module tb_div_26b;

    logic        CLK;
    logic        nRST;
    logic        start;
    logic        flush;
    logic [25:0] frac_in1;
    logic [25:0] frac_in2;
    logic        ready;
    logic        done;
    logic [25:0] frac_out;
    logic        overflow;
    logic        sticky;
    logic        div_by_zero;

    int checks;
    int failures;

    div_26b dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .start       (start),
        .flush       (flush),
        .frac_in1    (frac_in1),
        .frac_in2    (frac_in2),
        .ready       (ready),
        .done        (done),
        .frac_out    (frac_out),
        .overflow    (overflow),
        .sticky      (sticky),
        .div_by_zero (div_by_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // dividend, divisor, quotient, overflow, sticky
    logic [25:0] va [9] = '{26'h2000000, 26'h2000000, 26'h3000000,
                            26'h3000001, 26'h3000000, 26'h2000000,
                            26'h3FFFFFF, 26'h2000000, 26'h1FFFFFF};
    logic [25:0] vb [9] = '{26'h2000000, 26'h3000000, 26'h1000000,
                            26'h1000000, 26'h2000000, 26'h3FFFFFF,
                            26'h2000000, 26'h1000000, 26'h1000000};
    logic [25:0] vq [9] = '{26'h2000000, 26'h1555555, 26'h3000000,
                            26'h3000000, 26'h3000000, 26'h1000000,
                            26'h3FFFFFF, 26'h2000000, 26'h3FFFFFE};
    logic        vo [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                            1'b0, 1'b1, 1'b0};
    logic        vs [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                            1'b0, 1'b0, 1'b0};

    task automatic start_div(input logic [25:0] a, input logic [25:0] b);
        int n;
        n = 0;
        @(negedge CLK);
        while (!ready && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout ready=%b required=1", ready);
        end
        frac_in1 = a;
        frac_in2 = b;
        start    = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    // edge count after accept at which done is seen; -1 on timeout
    task automatic wait_done(output int e);
        e = 0;
        while (!done && e < 60) begin
            @(posedge CLK);
            #1;
            e++;
        end
        if (!done) e = -1;
    endtask

    task automatic test_reset;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", ready);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        checks++;
        if ({frac_out, overflow, sticky, div_by_zero} !== 29'd0) begin
            failures++;
            $display("FAIL reset_outputs frac=%h ovf=%b st=%b dbz=%b exp=0",
                     frac_out, overflow, sticky, div_by_zero);
        end
    endtask

    task automatic test_divide;
        int e;
        for (int i = 0; i < 9; i++) begin
            start_div(va[i], vb[i]);
            wait_done(e);
            checks++;
            if (e !== 26) begin
                failures++;
                $display("FAIL div%0d_latency got=%0d exp=26", i, e);
            end
            checks++;
            if (frac_out !== vq[i]) begin
                failures++;
                $display("FAIL div%0d_frac got=%h exp=%h", i, frac_out, vq[i]);
            end
            checks++;
            if ({overflow, sticky, div_by_zero} !== {vo[i], vs[i], 1'b0}) begin
                failures++;
                $display("FAIL div%0d_flags got=%b%b%b exp=%b%b0", i,
                         overflow, sticky, div_by_zero, vo[i], vs[i]);
            end
            repeat (3) @(posedge CLK);
            #1;
            checks++;
            if (frac_out !== vq[i] || done !== 1'b0 || ready !== 1'b1) begin
                failures++;
                $display("FAIL div%0d_hold frac=%h done=%b ready=%b exp=%h 0 1",
                         i, frac_out, done, ready, vq[i]);
            end
        end
    endtask

    task automatic test_div_by_zero;
        int e;
        start_div(26'h3000001, 26'h1000000);
        wait_done(e);
        start_div(26'h2000000, 26'h0);
        wait_done(e);
        checks++;
        if (e !== 0) begin
            failures++;
            $display("FAIL dbz_latency got=%0d exp=0", e);
        end
        checks++;
        if ({frac_out, div_by_zero, overflow, sticky} !== {26'h3FFFFFF, 3'b100}) begin
            failures++;
            $display("FAIL dbz_result frac=%h dbz=%b ovf=%b st=%b exp=3ffffff 1 0 0",
                     frac_out, div_by_zero, overflow, sticky);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL dbz_return ready=%b done=%b exp=1 0", ready, done);
        end
    endtask

    task automatic test_back_to_back;
        int e;
        start_div(26'h2000000, 26'h3000000);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        frac_in1 = 26'h3000000;
        frac_in2 = 26'h1000000;
        start    = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        checks++;
        if (frac_out !== 26'd0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL run_hidden frac=%h ready=%b exp=0 0", frac_out, ready);
        end
        wait_done(e);
        checks++;
        if (e !== 15 || frac_out !== 26'h1555555 || sticky !== 1'b1) begin
            failures++;
            $display("FAIL ignored_start e=%0d frac=%h st=%b exp=15 1555555 1",
                     e, frac_out, sticky);
        end
        start_div(26'h3000000, 26'h1000000);
        wait_done(e);
        checks++;
        if (e !== 26 || frac_out !== 26'h3000000 || overflow !== 1'b1 || sticky !== 1'b0) begin
            failures++;
            $display("FAIL b2b_result e=%0d frac=%h ovf=%b st=%b exp=26 3000000 1 0",
                     e, frac_out, overflow, sticky);
        end
    endtask

    task automatic test_reset_mid_run;
        int e;
        start_div(26'h2000000, 26'h3000000);
        repeat (12) @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 ||
            {frac_out, overflow, sticky, div_by_zero} !== 29'd0) begin
            failures++;
            $display("FAIL rst_mid ready=%b done=%b frac=%h ovf=%b st=%b dbz=%b exp=1 0 0",
                     ready, done, frac_out, overflow, sticky, div_by_zero);
        end
        @(negedge CLK);
        nRST = 1'b1;
        start_div(26'h2000000, 26'h2000000);
        wait_done(e);
        checks++;
        if (e !== 26 || frac_out !== 26'h2000000 || sticky !== 1'b0) begin
            failures++;
            $display("FAIL rst_after e=%0d frac=%h st=%b exp=26 2000000 0",
                     e, frac_out, sticky);
        end
    endtask

    task automatic test_flush;
        int  e;
        logic seen;
        start_div(26'h2000000, 26'h3000000);
        repeat (12) @(posedge CLK);
        @(negedge CLK);
        flush = 1'b1;
        @(posedge CLK);
        #1 flush = 1'b0;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_run_ready got=%b exp=1", ready);
        end
        seen = 1'b0;
        repeat (30) begin
            @(posedge CLK);
            #1;
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_done got=%b exp=0", seen);
        end
        start_div(26'h2000000, 26'h3000000);
        wait_done(e);
        flush = 1'b1;
        @(posedge CLK);
        #1 flush = 1'b0;
        checks++;
        if (frac_out !== 26'd0 || sticky !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_done frac=%h st=%b done=%b ready=%b exp=0 0 0 1",
                     frac_out, sticky, done, ready);
        end
        @(negedge CLK);
        frac_in1 = 26'h2000000;
        frac_in2 = 26'h2000000;
        start    = 1'b1;
        flush    = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        flush = 1'b0;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL flush_beats_start ready=%b done=%b exp=1 0", ready, done);
        end
        start_div(26'h3000000, 26'h2000000);
        wait_done(e);
        checks++;
        if (e !== 26 || frac_out !== 26'h3000000 || overflow !== 1'b0 || sticky !== 1'b0) begin
            failures++;
            $display("FAIL flush_fresh e=%0d frac=%h ovf=%b st=%b exp=26 3000000 0 0",
                     e, frac_out, overflow, sticky);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nRST     = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        frac_in1 = '0;
        frac_in2 = '0;
        repeat (3) @(posedge CLK);
        #1;
        test_reset;
        @(negedge CLK);
        nRST = 1'b1;
        test_divide;
        test_div_by_zero;
        test_back_to_back;
        test_reset_mid_run;
        test_flush;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_26b.md
# div_26b

Sequential 26-bit fraction divider for the floating-point unit. It is the divide-side counterpart to the 26-bit fraction multiplier. It takes two 26-bit fractions in 1.25 format (binary point after bit 25) and produces the quotient in the same format, using restoring division at one quotient bit per cycle behind a start/done handshake. The FPU divide path uses it between exponent subtraction and normalization/rounding.

## Interface
- Parameters: none; width is fixed at 26.
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous and active-low.
- start  in  1  request; accepted only on an edge where ready=1.
- flush  in  1  synchronous abort; returns to IDLE and has priority over start.
- frac_in1  in  26  dividend A, 1.25 format; sampled only on accept.
- frac_in2  in  26  divisor B, 1.25 format; sampled only on accept.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse when results become valid.
- frac_out  out  26  quotient, 1.25 format.
- overflow  out  1  A >= 2B; the quotient is of A/2 and the caller increments the exponent.
- sticky  out  1  final remainder is nonzero, or a dividend LSB was lost in pre-shift.
- div_by_zero  out  1  B == 0.

## Operation
- States are IDLE, RUN and DONE.
- On accept (IDLE with start=1, flush=0):
  - If B==0, go to DONE with frac_out=26'h3FFFFFF, div_by_zero=1, overflow=0, sticky=0.
  - Otherwise compute ovf = (A >= 2B) using a 27-bit compare.
  - Set A' = ovf ? A>>1 : A. Record lost_lsb = ovf & A[0].
  - Load the 27-bit remainder R = {1'b0, A'}, latch B, clear the quotient, set the counter to 25, go to RUN.
- Each RUN cycle:
  - If R >= {1'b0,B}, then q=1 and R=R-B; else q=0.
  - Then R = R<<1 (27 bits), and shift q into the quotient LSB.
  - The invariant R < 2B holds, so 27 bits never overflow.
- After the counter reaches 0 (26 iterations):
  - Go to DONE.
  - Set frac_out = floor(A'·2^25 / B).
  - Set sticky = (R != 0) | lost_lsb.
  - Set overflow = ovf.
- DONE lasts one cycle with done=1, then goes to IDLE.
- frac_out and the flags hold their values until the next accept, which clears them.
- frac_out[25]==0 means the quotient is below 1.0; the caller normalizes. This block sets no flag for that case.
- start while not ready is ignored; inputs are not re-sampled.
- flush in RUN or DONE: go to IDLE at the next edge, clear done, zero frac_out and all flags.
- nRST low at any time, including mid-RUN: immediately IDLE, counter 0, quotient 0, with all outputs at their reset values.

## Timing
- Reset values: ready=1, done=0, frac_out=0, overflow=0, sticky=0, div_by_zero=0.
- Normal latency with accept at edge E0:
  - RUN iterates on E1..E26.
  - done is high between E26 and E27; ready returns high after E27.
  - The earliest next accept is at E27, giving throughput of one divide per 27 cycles.
- Divide-by-zero latency: done is high between E0 and E1; ready returns after E1.
- frac_out and the flags are valid from the done cycle onward and are stable until the next accept.
- During RUN, intermediate quotient bits must not be visible on frac_out: drive it from a separate output register that is loaded on entry to DONE.
- Simultaneous start and flush in IDLE: flush wins; no accept.

## Test plan
- A=26'h2000000 (1.0), B=26'h2000000: done 26 cycles after accept, frac_out=26'h2000000, overflow=0, sticky=0.
- A=26'h2000000, B=26'h3000000 (1.5): frac_out=26'h1555555, sticky=1, overflow=0, frac_out[25]=0.
- A=26'h3000000 (1.5), B=26'h1000000 (0.5): overflow=1, frac_out=26'h3000000, sticky=0. Repeat with A=26'h3000001: sticky=1.
- B=0, any A: done one cycle after accept, frac_out=26'h3FFFFFF, div_by_zero=1.
- Pulse start at cycle 10 of RUN with different operands: ignored, first result unchanged. Then accept back-to-back at E27: second result correct.
- Assert nRST at cycle 13 of RUN: all outputs go to reset values immediately. Repeat with flush at cycle 13: IDLE next edge, no done pulse; a fresh divide then completes correctly.
